signal_debouncer: RTL and testbench

//  Multi-channel synchronizer + debounce filter for asynchronous board inputs (PG, ALERT#, PRSNT#).

---
 rtl/pdb_util_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 61 ++++++
 rtl/signal_debouncer.sv | 64 ++++++
 tb/tb_signal_debouncer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdb_util_pkg.sv
// Shared defaults and helpers for the power-good / presence input conditioning blocks.
package pdb_util_pkg;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_DEBOUNCE_TICKS = 16;
    localparam int GLITCH_CNT_W       = 8;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >>> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit synchronizer plus tick-based debounce filter with a registered change strobe.
// Exposes a glitch flag only when SIGNAL_DEBOUNCER_GLITCH_CNT_EN is defined.
module debounce_channel
    import pdb_util_pkg::*;
#(
    parameter int   SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int   DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter logic RST_VAL        = 1'b0
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iTick,
    input  logic iSig,
    output logic oSig,
    output logic oChange
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic oGlitch
`endif
);

    localparam int                CNT_W    = clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s;
    logic [CNT_W-1:0]       cnt;

    assign s = sync_p0[SYNC_STAGES-1];

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync_p0 <= {SYNC_STAGES{RST_VAL}};
            oSig    <= RST_VAL;
            oChange <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], iSig};
            oChange <= 1'b0;
            if (s != oSig) begin
                if (iTick) begin
                    if (cnt == CNT_LAST) begin
                        oSig    <= s;
                        oChange <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end else begin
                // Level fell back before acceptance: drop the partial count.
                cnt <= '0;
            end
        end
    end

`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    assign oGlitch = (s == oSig) && (cnt != '0);
`endif

endmodule

// File: rtl/signal_debouncer.sv
// Multi-channel synchronizer + debounce filter feeding the edge-detect stage.
// Optional shared glitch counter enabled by SIGNAL_DEBOUNCER_GLITCH_CNT_EN.
module signal_debouncer
    import pdb_util_pkg::*;
#(
    parameter int CH             = 4,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int RST_VAL        = 0
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iTick,
    input  logic [CH-1:0]           iSig,
    output logic [CH-1:0]           oSig,
    output logic [CH-1:0]           oChange
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    ,
    input  logic                    iGlitch_clr,
    output logic [GLITCH_CNT_W-1:0] oGlitch_cnt
`endif
);

`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    logic [CH-1:0] glitch;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .RST_VAL       (RST_VAL[0])
        ) u_ch (
            .iClk   (iClk),
            .iRst_n (iRst_n),
            .iTick  (iTick),
            .iSig   (iSig[g]),
            .oSig   (oSig[g]),
            .oChange(oChange[g])
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
            ,
            .oGlitch(glitch[g])
`endif
        );
    end

`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
        return (v == '1) ? v : v + GLITCH_CNT_W'(1);
    endfunction

    // Several channels glitching in one cycle count once; clear wins.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oGlitch_cnt <= '0;
        end else if (iGlitch_clr) begin
            oGlitch_cnt <= '0;
        end else if (|glitch) begin
            oGlitch_cnt <= sat_inc(oGlitch_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_signal_debouncer.sv
// Self-checking bench for signal_debouncer (CH=4, 2 sync stages, 16 ticks); glitch-counter
// checks are active when SIGNAL_DEBOUNCER_GLITCH_CNT_EN is defined.
module tb_signal_debouncer;

    localparam int CH    = 4;
    localparam int SYNC  = 2;
    localparam int TICKS = 16;

    logic          iClk = 1'b0;
    logic          iRst_n = 1'b0;
    logic          iTick = 1'b0;
    logic          iGlitch_clr = 1'b0;
    logic [CH-1:0] iSig = '0;
    logic [CH-1:0] oSig;
    logic [CH-1:0] oChange;
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0]    oGlitch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [CH-1:0] m_sync[$];
    logic [CH-1:0] m_sig;
    logic [CH-1:0] m_chg;
    int            m_ticks[CH];
    int            m_gcnt;
    logic [CH-1:0] cur;

    signal_debouncer #(
        .CH            (CH),
        .SYNC_STAGES   (SYNC),
        .DEBOUNCE_TICKS(TICKS),
        .RST_VAL       (0)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iTick      (iTick),
        .iSig       (iSig),
        .oSig       (oSig),
        .oChange    (oChange)
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
        ,
        .iGlitch_clr(iGlitch_clr),
        .oGlitch_cnt(oGlitch_cnt)
`endif
    );

    always #5 iClk = ~iClk;

    function automatic logic model_glitch_now();
        logic g;
        g = 1'b0;
        for (int ch = 0; ch < CH; ch++)
            if (m_sync[0][ch] == m_sig[ch] && m_ticks[ch] != 0) g = 1'b1;
        return g;
    endfunction

    // Advance the model by one clock using the inputs present at that edge.
    task automatic model_edge();
        logic [CH-1:0] s;
        logic          g;
        if (!iRst_n) begin
            m_sync.delete();
            for (int i = 0; i < SYNC; i++) m_sync.push_back('0);
            m_sig  = '0;
            m_chg  = '0;
            m_gcnt = 0;
            for (int ch = 0; ch < CH; ch++) m_ticks[ch] = 0;
        end else begin
            g = model_glitch_now();
            s = m_sync[0];
            m_sync.push_back(iSig);
            void'(m_sync.pop_front());
            m_chg = '0;
            for (int ch = 0; ch < CH; ch++) begin
                if (s[ch] != m_sig[ch]) begin
                    if (iTick) begin
                        m_ticks[ch] = m_ticks[ch] + 1;
                        if (m_ticks[ch] == TICKS) begin
                            m_sig[ch]   = s[ch];
                            m_chg[ch]   = 1'b1;
                            m_ticks[ch] = 0;
                        end
                    end
                end else begin
                    m_ticks[ch] = 0;
                end
            end
            if (iGlitch_clr) m_gcnt = 0;
            else if (g && m_gcnt < 255) m_gcnt = m_gcnt + 1;
        end
    endtask

    task automatic step(input logic [CH-1:0] sig, input logic tick, input logic clr);
        iSig        = sig;
        iTick       = tick;
        iGlitch_clr = clr;
        @(posedge iClk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        for (int c = 0; c < 3; c++) step(4'hF, 1'b0, 1'b0);
        checks++;
        if (oSig !== 4'h0 || oChange !== 4'h0) begin
            errors++;
            $display("FAIL reset_state oSig=%h oChange=%h required 0 0", oSig, oChange);
        end
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
        checks++;
        if (oGlitch_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_gcnt got=%0d required 0", oGlitch_cnt);
        end
`endif
        iRst_n = 1'b1;
        step(4'hF, 1'b0, 1'b0);
        checks++;
        if (oChange !== 4'h0) begin
            errors++;
            $display("FAIL reset_exit_change got=%h required 0", oChange);
        end
        cur = '0;
        for (int c = 0; c < 6; c++) begin
            step(cur, 1'b0, 1'b0);
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL reset_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
    endtask

    task automatic test_clean_edge();
        logic tick;
        cur[0] = 1'b1;
        for (int c = 0; c <= 170; c++) begin
            tick = (c >= 5) && ((c - 5) % 10 == 0);
            step(cur, tick, 1'b0);
            checks++;
            if (oSig[0] !== (c >= 155) || oChange[0] !== (c == 155)) begin
                errors++;
                $display("FAIL clean_edge c=%0d oSig0=%b oChange0=%b required %b %b", c, oSig[0], oChange[0], c >= 155, c == 155);
            end
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL clean_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
    endtask

    task automatic test_glitch();
        int   g_before;
        logic saw;
        g_before = m_gcnt;
        saw = 1'b0;
        for (int c = 0; c < 80; c++) begin
            cur[1] = (c < 50);
            step(cur, (c % 10) == 0, 1'b0);
            saw |= oChange[1];
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL glitch_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
        checks++;
        if (oSig[1] !== 1'b0 || saw !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject oSig1=%b sawChange=%b required 0 0", oSig[1], saw);
        end
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
        checks++;
        if (int'(oGlitch_cnt) !== g_before + 1) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d required %0d", oGlitch_cnt, g_before + 1);
        end
`endif
    endtask

    task automatic test_bounce();
        int   c;
        int   rises;
        int   last;
        int   rise_c;
        int   tcount;
        logic tick;
        c = 0; rises = 0; rise_c = -1; tcount = 0;
        for (int t = 0; t < 40; t++) begin
            if (t % 3 == 0) cur[2] = ~cur[2];
            for (int k = 0; k < 4; k++) begin
                step(cur, k == 0, 1'b0);
                if (oChange[2]) rises++;
                checks++;
                if (oSig !== m_sig || oChange !== m_chg) begin
                    errors++;
                    $display("FAIL bounce_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
                end
                c++;
            end
        end
        cur[2] = 1'b1;
        last = c;
        for (int k = 0; k < 120; k++) begin
            tick = (c % 4) == 0;
            step(cur, tick, 1'b0);
            if (tick && c >= last + SYNC && rise_c < 0) tcount++;
            if (oChange[2]) begin
                rises++;
                rise_c = c;
            end
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL bounce_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
            c++;
        end
        checks++;
        if (rises !== 1 || oSig[2] !== 1'b1 || tcount !== TICKS) begin
            errors++;
            $display("FAIL bounce_rise rises=%0d oSig2=%b ticks=%0d required 1 1 %0d", rises, oSig[2], tcount, TICKS);
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        int c3;
        int g_before;
        c0 = -1; c3 = -1;
        cur[0] = 1'b0;
        cur[3] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step(cur, (c % 2) == 0, 1'b0);
            if (oChange[0]) c0 = c;
            if (oChange[3]) c3 = c;
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL simul_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
        checks++;
        if (c0 < 0 || c0 !== c3) begin
            errors++;
            $display("FAIL simul_change cycle0=%0d cycle3=%0d required equal and seen", c0, c3);
        end
        g_before = m_gcnt;
        for (int c = 0; c < 16; c++) begin
            cur[1] = (c < 6);
            cur[2] = (c >= 6);
            step(cur, (c % 2) == 0, 1'b0);
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL simul_glitch_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
        checks++;
        if (int'(oGlitch_cnt) !== g_before + 1) begin
            errors++;
            $display("FAIL simul_glitch_cnt got=%0d required %0d", oGlitch_cnt, g_before + 1);
        end
`else
        if (g_before < 0) $display("unexpected negative model count");
`endif
    endtask

    task automatic test_random();
        logic clr;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 19) == 0) cur[$urandom_range(0, CH - 1)] ^= 1'b1;
            clr = ($urandom_range(0, 99) == 0);
            step(cur, $urandom_range(0, 2) == 0, clr);
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL random_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
            checks++;
            if (int'(oGlitch_cnt) !== m_gcnt) begin
                errors++;
                $display("FAIL random_gcnt c=%0d got=%0d required %0d", c, oGlitch_cnt, m_gcnt);
            end
`endif
        end
        cur = 4'b1100;
        for (int c = 0; c < 200; c++) step(cur, 1'b1, 1'b0);
        checks++;
        if (oSig !== 4'b1100) begin
            errors++;
            $display("FAIL random_settle oSig=%h required c", oSig);
        end
    endtask

    task automatic test_saturation_clear();
`ifdef SIGNAL_DEBOUNCER_GLITCH_CNT_EN
        logic hit;
        logic g_now;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 8; k++) begin
                cur[1] = (k < 4);
                step(cur, 1'b1, 1'b0);
            end
        end
        checks++;
        if (oGlitch_cnt !== 8'hFF || oSig[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_saturate got=%0d oSig1=%b required 255 0", oGlitch_cnt, oSig[1]);
        end
        hit = 1'b0;
        cur[1] = 1'b1;
        for (int k = 0; k < 4; k++) step(cur, 1'b1, 1'b0);
        cur[1] = 1'b0;
        for (int k = 0; k < 12 && !hit; k++) begin
            g_now = model_glitch_now();
            step(cur, 1'b1, g_now);
            hit = g_now;
        end
        checks++;
        if (hit !== 1'b1 || oGlitch_cnt !== 8'h00) begin
            errors++;
            $display("FAIL glitch_clear hit=%b got=%0d required 1 0", hit, oGlitch_cnt);
        end
        step(cur, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_reset_mid_pending();
        cur[0] = 1'b1;
        for (int c = 0; c < 8; c++) step(cur, 1'b1, 1'b0);
        iRst_n = 1'b0;
        step(cur, 1'b1, 1'b0);
        step(cur, 1'b1, 1'b0);
        checks++;
        if (oSig !== 4'h0 || oChange !== 4'h0) begin
            errors++;
            $display("FAIL midreset_state oSig=%h oChange=%h required 0 0", oSig, oChange);
        end
        iRst_n = 1'b1;
        for (int c = 0; c < 26; c++) begin
            step(cur, 1'b1, 1'b0);
            checks++;
            if (oSig !== ((c >= 17) ? cur : 4'h0) || oChange !== ((c == 17) ? cur : 4'h0)) begin
                errors++;
                $display("FAIL midreset_restart c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange,
                         (c >= 17) ? cur : 4'h0, (c == 17) ? cur : 4'h0);
            end
            checks++;
            if (oSig !== m_sig || oChange !== m_chg) begin
                errors++;
                $display("FAIL midreset_model c=%0d oSig=%h oChange=%h required %h %h", c, oSig, oChange, m_sig, m_chg);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SYNC; i++) m_sync.push_back('0);
        m_sig = '0; m_chg = '0; m_gcnt = 0; cur = '0;
        for (int ch = 0; ch < CH; ch++) m_ticks[ch] = 0;
        test_reset();
        test_clean_edge();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_random();
        test_saturation_clear();
        test_reset_mid_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
